multicycle_controller_v2: RTL and testbench
===========================================

// Module: multicycle_controller_v2
// PURPOSE
//  Parametrised next-generation multicycle MIPS control FSM, driving datapath muxes, register file, ALU op and memory.
//  Adds memory wait-state handshake, branches (BEQ/BNE), JAL/JR, halfword and word stores, and more ALU ops.
//  Resolves branches internally from the ALU zero flag. Flags illegal opcodes as HALT with a status output.
// PARAMETERS
//  ALUOP_W      5   width of ALUOP; codes below occupy [4:0], upper bits driven 0
//  MEM_TIMEOUT  16  max wait cycles for mem_ready (only with CTRL_MEM_TIMEOUT_EN); must be >=1
// PORTS
//  clk              in   1        clock, rising edge
//  reset            in   1        asynchronous, active-low reset
//  op, funct        in   6,6      IR[31:26], IR[5:0]
//  zero             in   1        ALU zero flag (valid in BRANCH state)
//  mem_ready        in   1        memory completes request this cycle
//  MemReq           out  1        memory access request
//  MemWrite         out  1        write strobe, qualified by MemReq
//  MemMode          out  3        000 word, 001 s-byte, 010 u-byte, 011 s-half, 100 u-half
//  PCWrite          out  1        load PC
//  PCSource         out  2        00 ALU, 01 ALUOut, 10 jump target, 11 rs (JR)
//  IorD, IRWrite    out  1,1      addr select (1=ALUOut); IR load
//  RegWrite         out  1        register file write
//  RegDst           out  2        00 rt, 01 rd, 10 r31
//  MemToReg         out  2        00 ALUOut, 01 MDR, 10 PC
//  ALUSrcA, ALUSrcB out  2,2      A: 00 PC, 01 rs, 10 shamt; B: 00 rt, 01 +4, 10 imm, 11 imm<<2
//  ALUOP            out  ALUOP_W  ADD 0,OR 1,AND 2,SUB 3,SLL 4,SRL 5,SRA 6,LUI 7,ORI 8,ANDI 9,SLT 10
//  halted, mem_err  out  1,1      in HALT; HALT entered by memory timeout
// BEHAVIOUR
//  - Reset low: state=RESET; all outputs 0 (Moore decode from state, plus op/funct/zero/mem_ready).
//  - Reset high again: RESET -> FETCH on next edge. Reset mid-access drops MemReq immediately.
//  - Handshake: FETCH, MEM_READ, MEM_WRITE hold MemReq=1 and remain until mem_ready=1. IRWrite/PCWrite in FETCH
//    and state advance happen only in the mem_ready=1 cycle; zero-wait memory gives 1 cycle per state.
//  - FETCH: IorD=0, ALUSrcA=00, ALUSrcB=01, ADD; on ready IRWrite=1, PCWrite=1, PCSource=00 -> DECODE.
//  - DECODE: ALUSrcB=11, ADD (branch target to ALUOut). Next by op:
//    LW/LH/LHU/LB/LBU/SW/SH/SB -> MEM_ADDR; RTYPE -> RTYPE_EX (funct JR -> JR); BEQ/BNE -> BRANCH;
//    J -> JUMP; JAL -> JAL; ADDI/ADDIU/ANDI/ORI/SLTI/LUI -> IMM_EX; other -> HALT.
//  - MEM_ADDR: A=01, B=10, ADD; loads -> MEM_READ, stores -> MEM_WRITE. MEM_READ: IorD=1, MemMode by op -> MEM_WB.
//  - MEM_WB: RegWrite=1, RegDst=00, MemToReg=01 -> FETCH. MEM_WRITE: IorD=1, MemWrite=1, MemMode by op -> FETCH.
//  - RTYPE_EX: A=10 for SLL/SRL/SRA, else 01; B=00; ALUOP from funct
//    (SLL,SRL,SRA,ADD,ADDU,SUB,SUBU,AND,OR,SLT); unknown funct -> HALT, else RTYPE_WB.
//  - RTYPE_WB: RegDst=01, RegWrite=1 -> FETCH.
//  - IMM_EX: A=01, B=10; ADDI/ADDIU ADD, ANDI, ORI, SLTI SLT, LUI -> IMM_WB (RegWrite=1, RegDst=00) -> FETCH.
//  - BRANCH: A=01, B=00, SUB, PCSource=01; PCWrite = zero (BEQ) or ~zero (BNE) -> FETCH.
//  - JUMP: PCWrite=1, PCSource=10 -> FETCH. JR: PCWrite=1, PCSource=11 -> FETCH.
//  - JAL: RegWrite=1, RegDst=10, MemToReg=10 (PC already +4), PCWrite=1, PCSource=10 -> FETCH.
//  - HALT: absorbing until reset; halted=1, all strobes 0. mem_err sticky until reset.
//  - State register 5 bits; unused encodings -> HALT (safe recovery).
// CONFIGURATION
//  CTRL_MEM_TIMEOUT_EN defined: wait counter clears on entering an access state, increments per mem_ready=0 cycle;
//    reaching MEM_TIMEOUT -> HALT with mem_err=1 next edge. mem_ready in the limit cycle wins (no error).
//  Undefined: waits indefinitely; no counter; mem_err tied 0.
// TESTING
//  1 reset low mid-FETCH with MemReq=1 -> all outputs 0 at once; release -> RESET, FETCH next cycle.
//  2 LW (op 100011), mem_ready low 3 cycles in FETCH and MEM_READ -> IRWrite single pulse; 5 states + 6 waits = 11 cycles.
//  3 BEQ zero=1 -> PCWrite=1, PCSource=01 in BRANCH; BNE zero=1 -> PCWrite=0; both 3 cycles.
//  4 JAL -> RegDst=10, MemToReg=10, RegWrite=1, PCWrite=1, PCSource=10 in the same cycle.
//  5 SH (op 101001) -> MemWrite=1, MemMode=011, IorD=1; SLL funct 000000 -> ALUSrcA=10, ALUOP=4.
//  6 op 111111 -> halted=1 after DECODE; with CTRL_MEM_TIMEOUT_EN, MEM_TIMEOUT=16, mem_ready=0 -> mem_err=1 after 16 waits.

Source files
------------

// File: rtl/multicycle_controller_v2.sv
// multicycle_controller_v2
// Multicycle MIPS control FSM with a memory wait-state handshake, internal
// branch resolution from the ALU zero flag, JAL/JR, sized memory accesses
// and an illegal-opcode HALT state.
//
// Optional feature: define CTRL_MEM_TIMEOUT_EN to bound the memory wait.
// After MEM_TIMEOUT consecutive mem_ready=0 cycles in one access state the
// FSM enters HALT and raises mem_err (sticky until reset). Without the macro
// the controller waits indefinitely and mem_err is tied low.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_RESET     | held in reset / first cycle after release, all outputs 0
// S_FETCH     | instruction fetch, waits for mem_ready, loads IR and PC+4
// S_DECODE    | register read, branch target into ALUOut, opcode dispatch
// S_MEM_ADDR  | effective address rs + imm
// S_MEM_READ  | data read, waits for mem_ready
// S_MEM_WB    | load result written to rt
// S_MEM_WRITE | data write, waits for mem_ready
// S_RTYPE_EX  | R-type ALU operation selected by funct
// S_RTYPE_WB  | R-type result written to rd
// S_IMM_EX    | immediate ALU operation
// S_IMM_WB    | immediate result written to rt
// S_BRANCH    | BEQ/BNE compare, PC loaded from ALUOut when taken
// S_JUMP      | J, PC loaded from jump target
// S_JR        | JR, PC loaded from rs
// S_JAL       | JAL, r31 <= PC (already +4), PC loaded from jump target
// S_HALT      | absorbing until reset, halted=1, all strobes 0

module multicycle_controller_v2 #(
    parameter int ALUOP_W     = 5,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               MemReq,
    output logic               MemWrite,
    output logic [2:0]         MemMode,
    output logic               PCWrite,
    output logic [1:0]         PCSource,
    output logic               IorD,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemToReg,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOP,
    output logic               halted,
    output logic               mem_err
);

    if (MEM_TIMEOUT < 1) begin : g_bad_timeout
        $error("MEM_TIMEOUT must be at least 1");
    end
    if (ALUOP_W < 5) begin : g_bad_aluop_w
        $error("ALUOP_W must be at least 5");
    end

    typedef enum logic [4:0] {
        S_RESET     = 5'd0,
        S_FETCH     = 5'd1,
        S_DECODE    = 5'd2,
        S_MEM_ADDR  = 5'd3,
        S_MEM_READ  = 5'd4,
        S_MEM_WB    = 5'd5,
        S_MEM_WRITE = 5'd6,
        S_RTYPE_EX  = 5'd7,
        S_RTYPE_WB  = 5'd8,
        S_IMM_EX    = 5'd9,
        S_IMM_WB    = 5'd10,
        S_BRANCH    = 5'd11,
        S_JUMP      = 5'd12,
        S_JR        = 5'd13,
        S_JAL       = 5'd14,
        S_HALT      = 5'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_OR   = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_SUB  = 5'd3;
    localparam logic [4:0] ALU_SLL  = 5'd4;
    localparam logic [4:0] ALU_SRL  = 5'd5;
    localparam logic [4:0] ALU_SRA  = 5'd6;
    localparam logic [4:0] ALU_LUI  = 5'd7;
    localparam logic [4:0] ALU_ORI  = 5'd8;
    localparam logic [4:0] ALU_ANDI = 5'd9;
    localparam logic [4:0] ALU_SLT  = 5'd10;

    state_t     state;
    state_t     state_next;
    logic [4:0] alu_code;
    logic       funct_ok;
    logic       timeout;

    // Access size for the memory stage; stores share the signed encodings
    function automatic logic [2:0] mem_mode_of(input logic [5:0] opcode);
        logic [2:0] mode;
        mode = 3'b000;
        case (opcode)
            OP_LB, OP_SB: mode = 3'b001;
            OP_LBU:       mode = 3'b010;
            OP_LH, OP_SH: mode = 3'b011;
            OP_LHU:       mode = 3'b100;
            default:      mode = 3'b000;
        endcase
        return mode;
    endfunction

    assign ALUOP = ALUOP_W'(alu_code);

    // State register; async reset forces RESET so every output drops at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_RESET;
        else        state <= state_next;
    end

    // Next-state and Moore/handshake output decode
    always_comb begin
        state_next = state;
        MemReq     = 1'b0;
        MemWrite   = 1'b0;
        MemMode    = 3'b000;
        PCWrite    = 1'b0;
        PCSource   = 2'b00;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 2'b00;
        MemToReg   = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        alu_code   = ALU_ADD;
        halted     = 1'b0;
        funct_ok   = 1'b1;
        case (state)
            S_RESET: state_next = S_FETCH;
            S_FETCH: begin
                MemReq  = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (op)
                    OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU,
                    OP_SW, OP_SH, OP_SB:                 state_next = S_MEM_ADDR;
                    OP_RTYPE: state_next = (funct == F_JR) ? S_JR : S_RTYPE_EX;
                    OP_BEQ, OP_BNE:                      state_next = S_BRANCH;
                    OP_J:                                state_next = S_JUMP;
                    OP_JAL:                              state_next = S_JAL;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
                    OP_SLTI, OP_LUI:                     state_next = S_IMM_EX;
                    default:                             state_next = S_HALT;
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                // Store opcodes are exactly the 101xxx group
                state_next = (op[5:3] == 3'b101) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                MemReq  = 1'b1;
                IorD    = 1'b1;
                MemMode = mem_mode_of(op);
                if (mem_ready) state_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemToReg   = 2'b01;
                state_next = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                IorD     = 1'b1;
                MemMode  = mem_mode_of(op);
                if (mem_ready) state_next = S_FETCH;
            end
            S_RTYPE_EX: begin
                ALUSrcB = 2'b00;
                ALUSrcA = (funct == F_SLL || funct == F_SRL || funct == F_SRA) ? 2'b10 : 2'b01;
                case (funct)
                    F_SLL:         alu_code = ALU_SLL;
                    F_SRL:         alu_code = ALU_SRL;
                    F_SRA:         alu_code = ALU_SRA;
                    F_ADD, F_ADDU: alu_code = ALU_ADD;
                    F_SUB, F_SUBU: alu_code = ALU_SUB;
                    F_AND:         alu_code = ALU_AND;
                    F_OR:          alu_code = ALU_OR;
                    F_SLT:         alu_code = ALU_SLT;
                    default:       funct_ok = 1'b0;
                endcase
                state_next = funct_ok ? S_RTYPE_WB : S_HALT;
            end
            S_RTYPE_WB: begin
                RegDst     = 2'b01;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_IMM_EX: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                case (op)
                    OP_ANDI: alu_code = ALU_ANDI;
                    OP_ORI:  alu_code = ALU_ORI;
                    OP_SLTI: alu_code = ALU_SLT;
                    OP_LUI:  alu_code = ALU_LUI;
                    default: alu_code = ALU_ADD;
                endcase
                state_next = S_IMM_WB;
            end
            S_IMM_WB: begin
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b01;
                alu_code   = ALU_SUB;
                PCSource   = 2'b01;
                PCWrite    = (op == OP_BNE) ? ~zero : zero;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                state_next = S_FETCH;
            end
            S_JR: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b11;
                state_next = S_FETCH;
            end
            S_JAL: begin
                RegWrite   = 1'b1;
                RegDst     = 2'b10;
                MemToReg   = 2'b10;
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                state_next = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_next = S_HALT;
        endcase
        if (timeout) state_next = S_HALT;
    end

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             in_access;

    assign in_access = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
    // A ready in the limit cycle completes normally, so only a miss there trips
    assign timeout   = in_access && !mem_ready && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    // Wait counter: restarts on every state change, counts missed-ready cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      wait_cnt <= '0;
        else if (state_next != state)    wait_cnt <= '0;
        else if (in_access && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
    end

    // Sticky memory-timeout flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       mem_err <= 1'b0;
        else if (timeout) mem_err <= 1'b1;
    end
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller_v2.sv
// Self-checking bench for multicycle_controller_v2: per-cycle expected output
// vectors are queued alongside the stimulus and compared at the falling edge.
module tb_multicycle_controller_v2;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       MemReq, MemWrite, PCWrite, IorD, IRWrite, RegWrite, halted, mem_err;
    logic [2:0] MemMode;
    logic [1:0] PCSource, RegDst, MemToReg, ALUSrcA, ALUSrcB;
    logic [4:0] ALUOP;

    always #5 clk = ~clk;

    multicycle_controller_v2 #(.ALUOP_W(5), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .MemReq(MemReq), .MemWrite(MemWrite), .MemMode(MemMode), .PCWrite(PCWrite),
        .PCSource(PCSource), .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOP(ALUOP), .halted(halted), .mem_err(mem_err)
    );

    typedef struct packed {
        logic       memreq;
        logic       memwrite;
        logic [2:0] memmode;
        logic       pcwrite;
        logic [1:0] pcsource;
        logic       iord;
        logic       irwrite;
        logic       regwrite;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [4:0] aluop;
        logic       halted;
        logic       mem_err;
    } out_t;

    out_t obs;
    assign obs = {MemReq, MemWrite, MemMode, PCWrite, PCSource, IorD, IRWrite, RegWrite,
                  RegDst, MemToReg, ALUSrcA, ALUSrcB, ALUOP, halted, mem_err};

    logic st_mr[$];
    logic st_z[$];
    out_t st_e[$];
    out_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic void add(logic mr, logic z, out_t e);
        st_mr.push_back(mr);
        st_z.push_back(z);
        st_e.push_back(e);
    endfunction

    function automatic out_t e_zero();
        out_t e = '0;
        return e;
    endfunction
    function automatic out_t e_fetch(logic r);
        out_t e = '0;
        e.memreq = 1'b1; e.srcb = 2'b01; e.irwrite = r; e.pcwrite = r;
        return e;
    endfunction
    function automatic out_t e_decode();
        out_t e = '0;
        e.srcb = 2'b11;
        return e;
    endfunction
    function automatic out_t e_mem_addr();
        out_t e = '0;
        e.srca = 2'b01; e.srcb = 2'b10;
        return e;
    endfunction
    function automatic out_t e_mem_read(logic [2:0] mode);
        out_t e = '0;
        e.memreq = 1'b1; e.iord = 1'b1; e.memmode = mode;
        return e;
    endfunction
    function automatic out_t e_mem_wb();
        out_t e = '0;
        e.regwrite = 1'b1; e.memtoreg = 2'b01;
        return e;
    endfunction
    function automatic out_t e_mem_write(logic [2:0] mode);
        out_t e = '0;
        e.memreq = 1'b1; e.memwrite = 1'b1; e.iord = 1'b1; e.memmode = mode;
        return e;
    endfunction
    function automatic out_t e_rtype_ex(logic [1:0] sa, logic [4:0] alu);
        out_t e = '0;
        e.srca = sa; e.aluop = alu;
        return e;
    endfunction
    function automatic out_t e_rtype_wb();
        out_t e = '0;
        e.regdst = 2'b01; e.regwrite = 1'b1;
        return e;
    endfunction
    function automatic out_t e_imm_ex(logic [4:0] alu);
        out_t e = '0;
        e.srca = 2'b01; e.srcb = 2'b10; e.aluop = alu;
        return e;
    endfunction
    function automatic out_t e_imm_wb();
        out_t e = '0;
        e.regwrite = 1'b1;
        return e;
    endfunction
    function automatic out_t e_branch(logic pcw);
        out_t e = '0;
        e.srca = 2'b01; e.aluop = 5'd3; e.pcsource = 2'b01; e.pcwrite = pcw;
        return e;
    endfunction
    function automatic out_t e_jump();
        out_t e = '0;
        e.pcwrite = 1'b1; e.pcsource = 2'b10;
        return e;
    endfunction
    function automatic out_t e_jr();
        out_t e = '0;
        e.pcwrite = 1'b1; e.pcsource = 2'b11;
        return e;
    endfunction
    function automatic out_t e_jal();
        out_t e = '0;
        e.regwrite = 1'b1; e.regdst = 2'b10; e.memtoreg = 2'b10;
        e.pcwrite = 1'b1; e.pcsource = 2'b10;
        return e;
    endfunction
    function automatic out_t e_halt(logic merr);
        out_t e = '0;
        e.halted = 1'b1; e.mem_err = merr;
        return e;
    endfunction

    task automatic do_reset();
        mem_ready = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        out_t e;
        int   step = 0;
        add(0, 0, e_zero());
        add(0, 0, e_zero());
        add(0, 0, e_fetch(0));
        add(0, 0, e_fetch(0));
        while (st_e.size() != 0) begin
            mem_ready = st_mr.pop_front();
            zero = st_z.pop_front();
            exp_q.push_back(st_e.pop_front());
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL reset step %0d: got %h want %h", step, obs, e);
            end
            step++;
            @(posedge clk); #1;
            if (step == 1) reset = 1'b1;
        end
        // Mid-FETCH reset with MemReq high must clear outputs without a clock edge
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        exp_q.push_back(e_zero());
        e = exp_q.pop_front();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL reset_async: got %h want %h", obs, e);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        op = 6'b000010;
        add(1, 0, e_zero());
        add(1, 0, e_fetch(1));
        add(1, 0, e_decode());
        add(1, 0, e_jump());
        while (st_e.size() != 0) begin
            mem_ready = st_mr.pop_front();
            zero = st_z.pop_front();
            exp_q.push_back(st_e.pop_front());
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL reset_release step %0d: got %h want %h", step, obs, e);
            end
            step++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_loads();
        out_t e;
        int   step = 0;
        logic [5:0] ops [3]  = '{6'b100011, 6'b100101, 6'b100000};
        logic [2:0] mode [3] = '{3'b000, 3'b100, 3'b001};
        for (int k = 0; k < 3; k++) begin
            op = ops[k];
            // Only the LW pass inserts three wait cycles per access state
            for (int w = 0; w < ((k == 0) ? 3 : 0); w++) add(0, 0, e_fetch(0));
            add(1, 0, e_fetch(1));
            add(1, 0, e_decode());
            add(1, 0, e_mem_addr());
            for (int w = 0; w < ((k == 0) ? 3 : 0); w++) add(0, 0, e_mem_read(mode[k]));
            add(1, 0, e_mem_read(mode[k]));
            add(1, 0, e_mem_wb());
            while (st_e.size() != 0) begin
                mem_ready = st_mr.pop_front();
                zero = st_z.pop_front();
                exp_q.push_back(st_e.pop_front());
                @(negedge clk);
                e = exp_q.pop_front();
                vectors++;
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL load op=%b step %0d: got %h want %h", op, step, obs, e);
                end
                step++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_branch();
        out_t e;
        int   step = 0;
        logic [5:0] ops [4] = '{6'b000100, 6'b000101, 6'b000100, 6'b000101};
        logic       zs  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       pcw [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            op = ops[k];
            add(1, zs[k], e_fetch(1));
            add(1, zs[k], e_decode());
            add(1, zs[k], e_branch(pcw[k]));
            while (st_e.size() != 0) begin
                mem_ready = st_mr.pop_front();
                zero = st_z.pop_front();
                exp_q.push_back(st_e.pop_front());
                @(negedge clk);
                e = exp_q.pop_front();
                vectors++;
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL branch op=%b zero=%b step %0d: got %h want %h", op, zero, step, obs, e);
                end
                step++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_jumps();
        out_t e;
        int   step = 0;
        for (int k = 0; k < 3; k++) begin
            op    = (k == 0) ? 6'b000010 : (k == 1) ? 6'b000011 : 6'b000000;
            funct = 6'b001000;
            add(1, 0, e_fetch(1));
            add(1, 0, e_decode());
            add(1, 0, (k == 0) ? e_jump() : (k == 1) ? e_jal() : e_jr());
            while (st_e.size() != 0) begin
                mem_ready = st_mr.pop_front();
                zero = st_z.pop_front();
                exp_q.push_back(st_e.pop_front());
                @(negedge clk);
                e = exp_q.pop_front();
                vectors++;
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL jump kind=%0d step %0d: got %h want %h", k, step, obs, e);
                end
                step++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_stores();
        out_t e;
        int   step = 0;
        logic [5:0] ops [3]  = '{6'b101001, 6'b101011, 6'b101000};
        logic [2:0] mode [3] = '{3'b011, 3'b000, 3'b001};
        for (int k = 0; k < 3; k++) begin
            op = ops[k];
            add(1, 0, e_fetch(1));
            add(1, 0, e_decode());
            add(1, 0, e_mem_addr());
            add(0, 0, e_mem_write(mode[k]));
            add(1, 0, e_mem_write(mode[k]));
            while (st_e.size() != 0) begin
                mem_ready = st_mr.pop_front();
                zero = st_z.pop_front();
                exp_q.push_back(st_e.pop_front());
                @(negedge clk);
                e = exp_q.pop_front();
                vectors++;
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL store op=%b step %0d: got %h want %h", op, step, obs, e);
                end
                step++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_rtype();
        out_t e;
        int   step = 0;
        logic [5:0] fn  [8] = '{6'b000000, 6'b000010, 6'b000011, 6'b100000,
                                6'b100011, 6'b100100, 6'b100101, 6'b101010};
        logic [1:0] sa  [8] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        logic [4:0] alu [8] = '{5'd4, 5'd5, 5'd6, 5'd0, 5'd3, 5'd2, 5'd1, 5'd10};
        op = 6'b000000;
        for (int k = 0; k < 8; k++) begin
            funct = fn[k];
            add(1, 0, e_fetch(1));
            add(1, 0, e_decode());
            add(1, 0, e_rtype_ex(sa[k], alu[k]));
            add(1, 0, e_rtype_wb());
            while (st_e.size() != 0) begin
                mem_ready = st_mr.pop_front();
                zero = st_z.pop_front();
                exp_q.push_back(st_e.pop_front());
                @(negedge clk);
                e = exp_q.pop_front();
                vectors++;
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL rtype funct=%b step %0d: got %h want %h", funct, step, obs, e);
                end
                step++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_imm();
        out_t e;
        int   step = 0;
        logic [5:0] ops [6] = '{6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001010, 6'b001111};
        logic [4:0] alu [6] = '{5'd0, 5'd0, 5'd9, 5'd8, 5'd10, 5'd7};
        for (int k = 0; k < 6; k++) begin
            op = ops[k];
            add(1, 0, e_fetch(1));
            add(1, 0, e_decode());
            add(1, 0, e_imm_ex(alu[k]));
            add(1, 0, e_imm_wb());
            while (st_e.size() != 0) begin
                mem_ready = st_mr.pop_front();
                zero = st_z.pop_front();
                exp_q.push_back(st_e.pop_front());
                @(negedge clk);
                e = exp_q.pop_front();
                vectors++;
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL imm op=%b step %0d: got %h want %h", op, step, obs, e);
                end
                step++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_halt();
        out_t e;
        int   step = 0;
        for (int k = 0; k < 2; k++) begin
            op    = (k == 0) ? 6'b111111 : 6'b000000;
            funct = 6'b111111;
            add(1, 0, e_fetch(1));
            add(1, 0, e_decode());
            if (k == 1) add(1, 0, e_rtype_ex(2'b01, 5'd0));
            add(1, 1, e_halt(0));
            add(0, 0, e_halt(0));
            add(1, 1, e_halt(0));
            while (st_e.size() != 0) begin
                mem_ready = st_mr.pop_front();
                zero = st_z.pop_front();
                exp_q.push_back(st_e.pop_front());
                @(negedge clk);
                e = exp_q.pop_front();
                vectors++;
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL halt case=%0d step %0d: got %h want %h", k, step, obs, e);
                end
                step++;
                @(posedge clk); #1;
            end
            do_reset();
        end
    endtask

    task automatic test_mem_wait();
        out_t e;
        int   step = 0;
`ifdef CTRL_MEM_TIMEOUT_EN
        op = 6'b100011;
        for (int w = 0; w < 15; w++) add(0, 0, e_fetch(0));
        add(1, 0, e_fetch(1));
        add(1, 0, e_decode());
        add(1, 0, e_mem_addr());
        for (int w = 0; w < 15; w++) add(0, 0, e_mem_read(3'b000));
        add(1, 0, e_mem_read(3'b000));
        add(1, 0, e_mem_wb());
        for (int w = 0; w < 16; w++) add(0, 0, e_fetch(0));
        add(0, 0, e_halt(1));
        add(1, 0, e_halt(1));
`else
        op = 6'b000010;
        for (int w = 0; w < 40; w++) add(0, 0, e_fetch(0));
        add(1, 0, e_fetch(1));
        add(1, 0, e_decode());
        add(1, 0, e_jump());
`endif
        while (st_e.size() != 0) begin
            mem_ready = st_mr.pop_front();
            zero = st_z.pop_front();
            exp_q.push_back(st_e.pop_front());
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL mem_wait step %0d: got %h want %h", step, obs, e);
            end
            step++;
            @(posedge clk); #1;
        end
        do_reset();
        add(0, 0, e_fetch(0));
        while (st_e.size() != 0) begin
            mem_ready = st_mr.pop_front();
            zero = st_z.pop_front();
            exp_q.push_back(st_e.pop_front());
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL mem_wait_after_reset: got %h want %h", obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d vectors applied", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        op        = 6'b000000;
        funct     = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_loads();
        test_branch();
        test_jumps();
        test_stores();
        test_rtype();
        test_imm();
        test_halt();
        test_mem_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
